// File: rtl/priority_dispatcher.sv
// priority_dispatcher
//   Collects per-line request pulses into a pending register and offers the
//   highest-index eligible (pending and unmasked) line to a consumer through a
//   valid/ready handshake. Each offer also carries the runner-up line. An offer
//   stays frozen until it is accepted. On accept, the offered line is cleared
//   and the grant counter advances. If anything else is still eligible, the
//   next offer follows with no idle cycle in between.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous active-high reset
//   set_req[7:0]   request pulses, bit i marks line i pending
//   mask[7:0]      bit i high makes line i ineligible for new offers
//   out_valid      an offer is presented
//   out_ready      consumer accepts the current offer
//   out_idx        offered line
//   out_next_idx   runner-up line at offer time
//   out_next_valid out_next_idx is meaningful
//   pending[7:0]   pending register
//   none           no eligible line is pending
//   overflow       sticky: a request arrived on a line that was already pending
//   grant_count    accepted grants, wraps
//
// state | meaning
// IDLE  | no offer presented, waiting for an eligible pending line
// OFFER | out_idx/out_next_idx presented and held until out_ready
module priority_dispatcher #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       set_req,
  input  logic [7:0]       mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic [2:0]       out_next_idx,
  output logic             out_next_valid,
  output logic [7:0]       pending,
  output logic             none,
  output logic             overflow,
  output logic [CNT_W-1:0] grant_count
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] eligible;
  logic [7:0] clr;
  logic [7:0] rem;
  logic [7:0] pick_src;
  logic [6:0] pick;
  logic       accept;
  logic       load_offer;

  // Returns {second_valid, second_idx, top_idx} for the two highest set bits.
  function automatic logic [6:0] pick2(input logic [7:0] v);
    logic [2:0] top;
    logic [2:0] nxt;
    logic       have_top;
    logic       have_nxt;
    top      = 3'd0;
    nxt      = 3'd0;
    have_top = 1'b0;
    have_nxt = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        if (!have_top) begin
          top      = i[2:0];
          have_top = 1'b1;
        end else if (!have_nxt) begin
          nxt      = i[2:0];
          have_nxt = 1'b1;
        end
      end
    end
    return {have_nxt, nxt, top};
  endfunction

  assign eligible = pending & ~mask;
  assign none     = (eligible == 8'h00);
  assign accept   = (state == OFFER) && out_ready;
  assign clr      = accept ? (8'b1 << out_idx) : 8'h00;
  // The follow-on offer uses only lines that were already pending.
  // Requests arriving in the accept cycle wait one more cycle.
  assign rem      = pending & ~clr & ~mask;
  assign pick     = pick2(pick_src);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt  = state;
    load_offer = 1'b0;
    pick_src   = eligible;
    case (state)
      IDLE: begin
        if (eligible != 8'h00) begin
          state_nxt  = OFFER;
          load_offer = 1'b1;
        end
      end
      OFFER: begin
        if (accept) begin
          pick_src = rem;
          if (rem != 8'h00) load_offer = 1'b1;
          else              state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    out_valid = (state == OFFER);
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= 8'h00;
      overflow       <= 1'b0;
      grant_count    <= '0;
      out_idx        <= 3'd0;
      out_next_idx   <= 3'd0;
      out_next_valid <= 1'b0;
    end else begin
      // A set in the same cycle as a clear wins, so that line stays pending.
      pending <= (pending & ~clr) | set_req;
      if ((set_req & pending & ~clr) != 8'h00) overflow <= 1'b1;
      if (accept) grant_count <= grant_count + CNT_W'(1);
      if (load_offer) begin
        out_idx        <= pick[2:0];
        out_next_idx   <= pick[5:3];
        out_next_valid <= pick[6];
      end
    end
  end

endmodule

// File: tb/tb_priority_dispatcher.sv
module tb_priority_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] set_req;
  logic [7:0] mask;
  logic       out_ready;

  logic       a_valid, a_nvalid, a_none, a_ovf;
  logic [2:0] a_idx, a_nidx;
  logic [7:0] a_pend;
  logic [7:0] a_cnt;

  logic       b_valid, b_nvalid, b_none, b_ovf;
  logic [2:0] b_idx, b_nidx;
  logic [7:0] b_pend;
  logic [1:0] b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] m_pend;
  logic       m_ovf;
  int         m_cnt;
  logic       m_valid;
  int         m_idx;
  int         m_nidx;
  logic       m_nvalid;
  logic [7:0] m_mask;

  priority_dispatcher #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .set_req(set_req), .mask(mask),
    .out_valid(a_valid), .out_ready(out_ready), .out_idx(a_idx),
    .out_next_idx(a_nidx), .out_next_valid(a_nvalid), .pending(a_pend),
    .none(a_none), .overflow(a_ovf), .grant_count(a_cnt)
  );

  priority_dispatcher #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .set_req(set_req), .mask(mask),
    .out_valid(b_valid), .out_ready(out_ready), .out_idx(b_idx),
    .out_next_idx(b_nidx), .out_next_valid(b_nvalid), .pending(b_pend),
    .none(b_none), .overflow(b_ovf), .grant_count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int top_bit(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_load(input logic [7:0] v);
    logic [7:0] rest;
    int s;
    m_valid = 1'b1;
    m_idx   = top_bit(v);
    rest    = v;
    rest[m_idx] = 1'b0;
    s = top_bit(rest);
    if (s >= 0) begin m_nidx = s; m_nvalid = 1'b1; end
    else        begin m_nidx = 0; m_nvalid = 1'b0; end
  endtask

  task automatic model_step(input logic [7:0] s, input logic [7:0] m, input logic r, input logic rst);
    logic [7:0] clrv;
    logic [7:0] rem;
    logic [7:0] el;
    m_mask = m;
    if (rst) begin
      m_pend = 0; m_ovf = 0; m_cnt = 0; m_valid = 0;
      m_idx = 0; m_nidx = 0; m_nvalid = 0;
      return;
    end
    clrv = (m_valid && r) ? (8'h01 << m_idx) : 8'h00;
    if ((s & m_pend & ~clrv) != 0) m_ovf = 1'b1;
    if (m_valid && r) begin
      m_cnt++;
      rem = m_pend & ~clrv & ~m;
      if (rem != 0) model_load(rem);
      else          m_valid = 1'b0;
    end else if (!m_valid) begin
      el = m_pend & ~m;
      if (el != 0) model_load(el);
    end
    m_pend = (m_pend & ~clrv) | s;
  endtask

  task automatic compare_all();
    check("valid",   a_valid, m_valid);
    check("pending", a_pend,  m_pend);
    check("none",    a_none,  ((m_pend & ~m_mask) == 0));
    check("ovf",     a_ovf,   m_ovf);
    check("cnt8",    a_cnt,   m_cnt % 256);
    check("cnt2",    b_cnt,   m_cnt % 4);
    check("b_valid", b_valid, m_valid);
    if (m_valid) begin
      check("idx",    a_idx,    m_idx);
      check("nvalid", a_nvalid, m_nvalid);
      if (m_nvalid) check("nidx", a_nidx, m_nidx);
    end
  endtask

  task automatic cyc(input logic [7:0] s, input logic [7:0] m, input logic r, input logic rst);
    set_req   = s;
    mask      = m;
    out_ready = r;
    reset     = rst;
    model_step(s, m, r, rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    set_req = 0; mask = 0; out_ready = 0; reset = 1;
    m_mask = 0;
    model_step(0, 0, 0, 1);

    // reset state
    cyc(8'hFF, 0, 1, 1);
    cyc(0, 0, 0, 1);
    check("rst_idx",   a_idx,    0);
    check("rst_nidx",  a_nidx,   0);
    check("rst_nval",  a_nvalid, 0);
    check("rst_valid", a_valid,  0);

    // basic latency
    cyc(8'h01, 0, 0, 0);
    check("lat_n1_valid", a_valid, 0);
    check("lat_n1_pend",  a_pend,  8'h01);
    cyc(0, 0, 0, 0);
    check("lat_valid",  a_valid,  1);
    check("lat_idx",    a_idx,    0);
    check("lat_nvalid", a_nvalid, 0);
    check("lat_none",   a_none,   0);

    // priority, back-to-back
    cyc(0, 0, 0, 1);
    cyc(8'hA4, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("pri_idx7", a_idx, 7); check("pri_n5", a_nidx, 5);
    cyc(0, 0, 1, 0);
    check("pri_idx5", a_idx, 5); check("pri_n2", a_nidx, 2);
    cyc(0, 0, 1, 0);
    check("pri_idx2", a_idx, 2); check("pri_nv0", a_nvalid, 0);
    cyc(0, 0, 1, 0);
    check("pri_idle", a_valid, 0);
    check("pri_cnt",  a_cnt,   3);
    check("pri_pend", a_pend,  0);

    // stability
    cyc(0, 0, 0, 1);
    cyc(8'h08, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(8'h80, 8'h08, 0, 0);
    check("stab_idx_a", a_idx, 3);
    cyc(0, 8'h08, 0, 0);
    check("stab_idx_b", a_idx, 3);
    check("stab_valid", a_valid, 1);
    cyc(0, 8'h08, 1, 0);
    check("stab_next7", a_idx, 7);
    cyc(0, 8'h80, 0, 0);
    cyc(0, 8'h80, 1, 0);
    check("stab_masked_idle", a_valid, 0);
    check("stab_masked_pend", a_pend, 8'h00);

    // collisions
    cyc(0, 0, 0, 1);
    cyc(8'h10, 0, 0, 0);
    cyc(8'h10, 0, 0, 0);
    check("col_ovf", a_ovf, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("col_ovf_sticky", a_ovf, 1);
    cyc(0, 0, 0, 1);
    cyc(8'h10, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(8'h10, 0, 1, 0);
    check("col_setwin_pend", a_pend[4], 1);
    check("col_setwin_ovf",  a_ovf, 0);
    cyc(0, 0, 0, 0);
    check("col_reoffer", a_idx, 4);

    // wrap
    cyc(0, 0, 0, 1);
    cyc(8'h1F, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    check("wrap_cnt2", b_cnt, 1);
    check("wrap_cnt8", a_cnt, 5);

    // mid-offer reset
    cyc(8'h30, 0, 0, 0);
    cyc(8'h10, 0, 0, 0);
    cyc(8'h01, 0, 1, 1);
    check("mrst_valid", a_valid, 0);
    check("mrst_pend",  a_pend,  0);
    check("mrst_ovf",   a_ovf,   0);
    check("mrst_cnt",   a_cnt,   0);

    // random
    begin
      logic [7:0] rm;
      logic [7:0] rs;
      rm = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(3) == 0) rm = 8'($urandom) & 8'($urandom);
        rs = ($urandom_range(2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
        cyc(rs, rm, 1'($urandom_range(1)), ($urandom_range(149) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_dispatcher.md
PRIORITY_DISPATCHER -- requirements
Module: priority_dispatcher

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the grant counter.
REQ-002 The block SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port set_req, input, 8, per-line request pulses; bit i high marks line i pending.
REQ-005 The block SHALL have port mask, input, 8, per-line eligibility mask; bit i high makes line i ineligible.
REQ-006 The block SHALL have port out_valid, output, 1, meaning a grant offer is presented.
REQ-007 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the offer.
REQ-008 The block SHALL have port out_idx, output, 3, the index of the offered line.
REQ-009 The block SHALL have port out_next_idx, output, 3, the runner-up index at offer time.
REQ-010 The block SHALL have port out_next_valid, output, 1, meaning out_next_idx is meaningful.
REQ-011 The block SHALL have port pending, output, 8, the pending register.
REQ-012 The block SHALL have port none, output, 1, meaning no eligible line is pending.
REQ-013 The block SHALL have port overflow, output, 1, a sticky flag for a request arriving on an already-pending line.
REQ-014 The block SHALL have port grant_count, output, CNT_W, the count of accepted grants.

Function
REQ-015 The block SHALL compute eligible = pending & ~mask combinationally from the registered pending value.
REQ-016 The block SHALL drive none = (eligible == 0) combinationally.
REQ-017 On each edge, pending SHALL load (pending & ~clr) | set_req, where clr is one-hot of out_idx when out_valid && out_ready, else 0.
REQ-018 When a set_req bit and clr hit the same line in one cycle, set SHALL win and the bit SHALL remain pending.
REQ-019 overflow SHALL set when set_req[i] is high, pending[i] is high and clr[i] is low, and SHALL clear only on reset.
REQ-020 The FSM SHALL have two states: IDLE, with out_valid=0, and OFFER, with out_valid=1.
REQ-021 In IDLE, when eligible != 0, the FSM SHALL move to OFFER on the next edge, latching out_idx as the highest set bit of eligible.
REQ-022 On that IDLE-to-OFFER edge, out_next_idx SHALL latch the second-highest set bit of eligible, with out_next_valid=1 if at least 2 bits are set, else out_next_idx=0 and out_next_valid=0.
REQ-023 Request latency SHALL be: set_req high in cycle N, pending visible in N+1, out_valid high in N+2, with no other activity.
REQ-024 In OFFER with out_ready=0, out_idx, out_next_idx and out_next_valid SHALL hold stable; higher-priority arrivals and mask changes, including masking the offered line, SHALL NOT alter or withdraw the offer.
REQ-025 In OFFER with out_ready=1 (accept), the block SHALL clear the offered line and increment grant_count by 1, wrapping from 2^CNT_W-1 to 0.
REQ-026 On accept, the block SHALL compute rem = pending & ~clr & ~mask, excluding the same-cycle set_req.
REQ-027 If rem != 0, the FSM SHALL stay in OFFER and load a new out_idx / out_next_idx from rem per REQ-021/022, giving a back-to-back offer with no bubble.
REQ-028 If rem == 0, the FSM SHALL return to IDLE.
REQ-029 out_ready while in IDLE SHALL have no effect.

Reset
REQ-030 When reset is high at an edge, the block SHALL clear pending, overflow and grant_count to 0, enter IDLE, and drive out_valid=0, out_idx=0, out_next_idx=0 and out_next_valid=0.
REQ-031 During reset, set_req SHALL be ignored.
REQ-032 Reset asserted while in OFFER SHALL drop the offer without counting a grant.

Verification
REQ-033 Scenario basic latency: set_req=8'h01 for one cycle, mask=0, out_ready=0 -> out_valid=1 two edges later, out_idx=0, out_next_valid=0, none=0.
REQ-034 Scenario priority: set_req=8'hA4 in one cycle, then out_ready held 1 -> successive offers out_idx=7 (next 5), out_idx=5 (next 2), out_idx=2 (next_valid=0), one per cycle; then IDLE, grant_count=3, pending=0.
REQ-035 Scenario stability: offer out_idx=3 held with out_ready=0 while set_req=8'h80 and mask=8'h08 -> out_idx stays 3 until accepted; the next offer is 7 only if mask[7]=0.
REQ-036 Scenario collisions: pending[4]=1 with another set_req=8'h10 -> overflow=1 and stays 1; set_req[4] on the accept cycle of line 4 -> pending[4]=1 afterwards and overflow stays 0.
REQ-037 Scenario wrap: with CNT_W=2, five accepts -> grant_count reads 1.
REQ-038 Scenario mid-offer reset: reset asserted in OFFER -> next cycle out_valid=0, pending=0, overflow=0, grant_count=0.
